// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Package  : spi_pkg
// Brief    : Shared state encoding and limits for the SPI master.
// Revision : 1.0
// ============================================================================
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_t;

  // The miso synchronizer delay must fit inside one sclk half-period.
  localparam int MIN_CLK_DIV = 4;
  localparam int SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer, async active-low reset, resets to 0.
// Revision : 1.0
// ============================================================================
module sync_2ff
  import spi_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Brief    : Mode-0 SPI controller, one full-duplex DATA_W frame per start.
//            Define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order.
// Revision : 1.0
// ============================================================================
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              cs_bar,
  output logic              sclk,
  output logic              mosi,
  output logic              ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_done
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0] FALL_LAST = EDGE_W'(2 * DATA_W - 1);

  generate
    if (CLK_DIV < MIN_CLK_DIV) begin : g_clk_div_check
      $error("spi_master: CLK_DIV must be >= %0d", MIN_CLK_DIV);
    end
    if (DATA_W < 2) begin : g_data_w_check
      $error("spi_master: DATA_W must be >= 2");
    end
  endgenerate

  spi_state_t        state;
  spi_state_t        next_state;
  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] rx_next;
  logic              first_bit;
  logic              next_bit;
  logic              miso_sync;
  logic              phase_end;
  logic              load;
  logic              sclk_toggle;
  logic              sclk_rise;
  logic              drive_next;
  logic              cs_bar_d;
  logic              ready_d;
  logic              done_d;

  sync_2ff u_miso_sync (
    .clk   (clk),
    .reset (reset),
    .d     (miso),
    .q     (miso_sync)
  );

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign first_bit = tx_data[0];
  assign next_bit  = tx_shift[1];
  assign tx_next   = tx_shift >> 1;
  assign rx_next   = {miso_sync, rx_shift[DATA_W-1:1]};
`else
  assign first_bit = tx_data[DATA_W-1];
  assign next_bit  = tx_shift[DATA_W-2];
  assign tx_next   = tx_shift << 1;
  assign rx_next   = {rx_shift[DATA_W-2:0], miso_sync};
`endif

  assign phase_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (spi_start) next_state = SETUP;
      SETUP:   if (phase_end) next_state = SHIFT;
      SHIFT:   if (phase_end && (edge_cnt == EDGE_LAST)) next_state = HOLD;
      HOLD:    if (phase_end) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // SHIFT keeps one extra low phase after the last falling edge before HOLD.
  always_comb begin
    load        = (state == IDLE) && spi_start;
    sclk_toggle = phase_end &&
                  ((state == SETUP) || ((state == SHIFT) && (edge_cnt != EDGE_LAST)));
    sclk_rise   = sclk_toggle && !sclk;
    drive_next  = sclk_toggle && sclk && (edge_cnt != FALL_LAST);
    cs_bar_d    = !((next_state == SETUP) || (next_state == SHIFT) || (next_state == HOLD));
    ready_d     = (next_state == IDLE);
    done_d      = (next_state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      cs_bar   <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ready    <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      if ((state == IDLE) || (state == DONE) || phase_end) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (load) begin
        edge_cnt <= '0;
      end else if (sclk_toggle) begin
        edge_cnt <= edge_cnt + EDGE_W'(1);
      end

      if (sclk_toggle) begin
        sclk <= !sclk;
      end

      if (load) begin
        tx_shift <= tx_data;
        mosi     <= first_bit;
      end else if (drive_next) begin
        tx_shift <= tx_next;
        mosi     <= next_bit;
      end

      if (load) begin
        rx_shift <= '0;
      end else if (sclk_rise) begin
        rx_shift <= rx_next;
      end

      if (done_d) begin
        rx_data <= rx_shift;
      end

      cs_bar   <= cs_bar_d;
      ready    <= ready_d;
      rx_valid <= done_d;
      tx_done  <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

Mode-0 SPI controller (CPOL=0, CPHA=0) that drives `cs_bar`, `sclk` and `mosi` and samples `miso`. It is the initiator counterpart of the existing `spi_slave` and is used to exercise that block on-chip or in loopback benches. The controller shifts one `DATA_W`-bit frame per accepted `spi_start`, with full-duplex receive, on the same `clk` as the rest of the design.

## Interface
- `DATA_W`, 8, frame width in bits (≥2).
- `CLK_DIV`, 8, `clk` cycles per `sclk` half-period (≥4, checked by elaboration assertion).
- `clk`  input  1  system clock, all logic on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `spi_start`  input  1  request a frame; accepted only when `ready`=1.
- `tx_data`  input  DATA_W  frame to transmit, captured on the accept cycle.
- `miso`  input  1  serial data from the slave (asynchronous to `clk`).
- `cs_bar`  output  1  chip select, active low.
- `sclk`  output  1  serial clock, idle low.
- `mosi`  output  1  serial data to the slave.
- `ready`  output  1  idle, can accept `spi_start`.
- `rx_data`  output  DATA_W  last received frame, held until the next frame completes.
- `rx_valid`  output  1  one-cycle pulse when `rx_data` updates.
- `tx_done`  output  1  one-cycle pulse at frame end.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE. All outputs are registered.
- **IDLE**: `ready`=1, `cs_bar`=1, `sclk`=0. If `spi_start`=1, latch `tx_data` into the shift register and go to SETUP.
- **SETUP**: `cs_bar`=0, `mosi` = first bit, `ready`=0. Lasts CLK_DIV cycles, then go to SHIFT.
- **SHIFT**: `sclk` toggles every CLK_DIV cycles, starting with a rising edge.
  - Rising edge: sample synchronized `miso` into the receive shift register.
  - Falling edge: drive the next bit on `mosi`.
  - After DATA_W rising and DATA_W falling edges, go to HOLD. No `mosi` update occurs on the final falling edge.
- **HOLD**: `sclk`=0, `cs_bar`=0 for CLK_DIV cycles, then go to DONE.
- **DONE** (1 cycle): `cs_bar`=1, `rx_data` updated, `rx_valid`=1, `tx_done`=1. Next state is IDLE.
- Default bit order is MSB first.
- `miso` passes through a 2-flop synchronizer before it is sampled. This is why CLK_DIV must be ≥4.
- `spi_start` while `ready`=0 is ignored and not queued. `tx_data` changes after the accept cycle have no effect.
- Reset asserted at any time, including mid-frame: outputs go to reset values immediately (asynchronously). The partial frame is discarded with no `rx_valid` or `tx_done`. The FSM returns to IDLE.
- Reset values: `cs_bar`=1, `sclk`=0, `mosi`=0, `ready`=1, `rx_data`=0, `rx_valid`=0, `tx_done`=0.

## Timing
- Accept edge (`spi_start`·`ready` sampled): `cs_bar` falls and `ready` falls on that same edge.
- First `sclk` rise: CLK_DIV cycles after `cs_bar` falls.
- Each `sclk` high or low phase lasts exactly CLK_DIV cycles.
- `cs_bar` stays low for (2·DATA_W+2)·CLK_DIV cycles: 144 cycles with defaults.
- DONE cycle: `rx_valid` and `tx_done` pulse high, coincident with `cs_bar`=1.
- `ready` returns to 1 one cycle after DONE.
- Minimum start-to-start spacing: (2·DATA_W+2)·CLK_DIV+2 cycles.
- A `spi_start` held high in IDLE immediately starts the next frame.
- `miso` sample point: the `clk` edge on which `sclk` rises. It uses the value `miso` had 2 cycles earlier (synchronizer latency).

## Configuration
- `SPI_MASTER_LSB_FIRST_EN`
  - Defined: LSB shifted first on `mosi`. Received bits fill from the MSB end, so `rx_data[0]` is the first bit received.
  - Undefined: MSB first on both directions, matching `spi_slave`.

## Structure
- Package `spi_pkg`:
  - `spi_state_t` enum (IDLE, SETUP, SHIFT, HOLD, DONE).
  - Localparams for the minimum CLK_DIV and the synchronizer depth.
- Sub-module `sync_2ff`: 2-flop synchronizer for `miso`, async active-low reset, reset value 0.
- The divider counter, edge counter and shift registers live in `spi_master`.

## Test plan
- **Reset:** assert `reset`=0 → all outputs at reset values; `spi_start` pulses are ignored while reset is held.
- **Single frame:** `tx_data`=8'hA5, slave model returns 8'h3C, defaults → `mosi` bits 1,0,1,0,0,1,0,1 sampled at `sclk` rises; `cs_bar` low for 144 cycles; `rx_data`=8'h3C with `rx_valid` and `tx_done` as single-cycle pulses.
- **Busy rejection:** `spi_start` pulsed mid-frame with `tx_data`=8'hFF → the frame in flight completes unchanged; no second frame is started.
- **Back-to-back:** `spi_start` held high with 8'h01 then 8'h80 → two frames; `cs_bar` high for exactly 2 cycles between them; `rx_data` updates twice.
- **Reset mid-frame:** `reset`=0 after the 3rd `sclk` rise → `cs_bar`=1 and `sclk`=0 immediately; no `rx_valid`; the next frame after release is correct.
- **LSB-first build:** with `SPI_MASTER_LSB_FIRST_EN` defined, `tx_data`=8'h01 → first `mosi` bit 1, remaining seven 0; the slave sending bits 1,0,0,0,0,0,0,0 yields `rx_data`=8'h01.
